serial_word_receiver: RTL
=========================

# serial_word_receiver

Serial-to-parallel receiver that reassembles words shifted out one bit at a time by a universal-shift-register-style transmitter. Each bit arrives as one strobed bit. The block accumulates WIDTH bits in either MSB-first or LSB-first order and presents the completed word on a valid/ready output. It sits at the far end of the serial link and feeds downstream parallel logic.

## Interface
- WIDTH, 4: data word width in bits, must be at least 2.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous reset, active-high. Clock is clk.
- s_valid  in  1  serial bit strobe; s_data is sampled on each cycle where s_valid=1.
- s_data  in  1  serial data bit.
- msb_first  in  1  bit order for the current word (1 = MSB first, 0 = LSB first); latched with the first bit of each word.
- frame_clr  in  1  discards any partial word and resynchronises to a word boundary.
- m_data  out  WIDTH  received word.
- m_valid  out  1  m_data holds an undelivered word.
- m_ready  in  1  downstream accepts the word.
- overrun  out  1  sticky flag; a completed word was dropped.
- parity_err  out  1  parity result for the word on m_data; tied to 0 unless parity is compiled in.

## Operation
- FSM states:
  - IDLE: bit count = 0.
  - SHIFT: bit count between 1 and WIDTH-1.
  - PARITY: present only with the macro; waits for the parity bit.
- IDLE -> SHIFT on the first accepted bit. At that point msb_first is latched into order_q.
- Shift rule for each accepted bit:
  - order_q=1: shreg <= {shreg[WIDTH-2:0], s_data}, a left shift.
  - order_q=0: shreg <= {s_data, shreg[WIDTH-1:1]}, a right shift.
- Without the macro, SHIFT -> IDLE on the WIDTH-th accepted bit, and the word completes.
- Gaps are allowed. Cycles with s_valid=0 hold all state. There is no timeout.
- Word completion, by case:
  - m_valid=0: load the output register (m_data and parity_err) and set m_valid=1.
  - m_valid=1 and m_ready=1 in the same cycle: the old word is handed off and the new word loaded; m_valid stays 1.
  - m_valid=1 and m_ready=0: the new word is dropped, m_data is unchanged, and overrun is set to 1.
- Handshake: a transfer occurs on any cycle where m_valid and m_ready are both 1. After it, m_valid clears unless a word completes in that same cycle. While m_valid=1, m_data stays stable.
- Reception continues while the output waits. The shift register is separate from the output register.
- frame_clr: bit count goes to 0 and the FSM goes to IDLE. m_data, m_valid and overrun are unaffected. If frame_clr and s_valid occur in the same cycle, frame_clr wins and the bit is dropped.
- overrun clears only on reset.

## Timing
- Reset values: m_data=0, m_valid=0, overrun=0, parity_err=0, FSM=IDLE, internal shift register=0.
- Reset mid-word discards the partial word.
- Latency: m_valid rises on the clock edge that samples the final bit (the WIDTH-th data bit, or the parity bit with the macro). It is visible in the following cycle.
- Minimum word period is WIDTH cycles, or WIDTH+1 with parity.
- m_ready has no combinational path to any output.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - After WIDTH data bits, SHIFT -> PARITY.
  - The next accepted bit is an even-parity bit: the XOR of the data bits and the parity bit must be 0.
  - The word completes on the parity bit, and parity_err = XOR of the data bits and the parity bit.
  - parity_err is registered with m_data and valid while m_valid=1.
  - frame_clr in the PARITY state returns the FSM to IDLE.
- SERIAL_RX_PARITY_EN undefined: there is no PARITY state, parity_err is constant 0, and the word completes on the WIDTH-th bit.

## Structure
- Package serial_rx_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the bit-count width function, $clog2(WIDTH+1);
  - order constants MSB_FIRST=1 and LSB_FIRST=0.
- Sub-module serial_rx_shifter is the direction-selectable WIDTH-bit shift register with enable and clear. The top level holds the FSM, bit counter, output register and flags.

## Test plan
- Reset: assert reset for 2 cycles with s_valid toggling -> m_valid=0, m_data=0, overrun=0, parity_err=0.
- MSB-first, m_ready=1: msb_first=1, bits 1,0,1,1 on consecutive cycles -> m_data=4'b1011, m_valid high one cycle after the 4th bit, held 1 cycle.
- LSB-first with gaps: msb_first=0, bits 1,0,1,1 with s_valid low between each bit -> m_data=4'b1101. Also toggle msb_first mid-word -> the order does not change within the word.
- Backpressure/overrun: m_ready=0, send 0xA then 0x5 MSB-first -> m_data stays 0xA and overrun=1. Then m_ready=1 -> m_valid=0 the next cycle and overrun stays 1.
- Resync: send 2 bits, then frame_clr together with s_valid, then bits 0,1,1,0 MSB-first -> m_data=0x6. No word is delivered for the partial bits.
- Parity (macro on): bits 1,0,1,1 then parity 1 -> m_data=0xB, parity_err=0. Repeat with parity 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial word receiver.
// Also used by the optional parity build (SERIAL_RX_PARITY_EN).
package serial_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } rx_state_e;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Direction-selectable shift register with enable and synchronous clear.
// q_next is the value the register takes on the next edge when not cleared.
module serial_rx_shifter
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             order,
  input  logic             din,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] shreg_q;

  always_comb begin
    q_next = shreg_q;
    if (en) begin
      if (order == LSB_FIRST) q_next = {din, shreg_q[WIDTH-1:1]};
      else                    q_next = {shreg_q[WIDTH-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) shreg_q <= '0;
    else              shreg_q <= q_next;
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with valid/ready output and sticky overrun flag.
// Define SERIAL_RX_PARITY_EN to expect a trailing even-parity bit per word.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             msb_first,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             order_q;
  logic             accept;
  logic             shift_en;
  logic             shift_order;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid_q;
  logic             overrun_q;

`ifdef SERIAL_RX_PARITY_EN
  logic par_q;
  logic perr_q;
  logic word_perr;
`endif

  // frame_clr beats a coincident bit strobe
  assign accept = s_valid & ~frame_clr;

  serial_rx_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .clr    (frame_clr),
    .en     (shift_en),
    .order  (shift_order),
    .din    (s_data),
    .q_next (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      order_q   <= MSB_FIRST;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && state_q == StIdle) order_q <= msb_first;
`ifdef SERIAL_RX_PARITY_EN
      if (accept && state_q == StIdle)       par_q <= s_data;
      else if (accept && state_q == StShift) par_q <= par_q ^ s_data;
`endif
      if (word_done && (!m_valid_q || m_ready)) begin
        m_data_q  <= word;
        m_valid_q <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        perr_q    <= word_perr;
`endif
      end else if (word_done) begin
        overrun_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_clr) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (s_valid) begin
      unique case (state_q)
        StIdle: begin
          state_d = StShift;
          cnt_d   = CntW'(1);
        end
        StShift: begin
          if (cnt_q == LastCnt) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = StParity;
            cnt_d   = CntW'(WIDTH);
`else
            state_d = StIdle;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    shift_order = (state_q == StIdle) ? msb_first : order_q;
    shift_en    = accept && (state_q != StParity);
`ifdef SERIAL_RX_PARITY_EN
    word_done   = accept && (state_q == StParity);
    word_perr   = par_q ^ s_data;
`else
    word_done   = accept && (state_q == StShift) && (cnt_q == LastCnt);
`endif
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
